// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Brief    : Shared types and constants for the data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_DBG = 1'b1;

    localparam int WCNT_W = 4;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Combinational two-way round-robin pick (bit 0 = cpu, bit 1 = dbg).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = GNT_CPU;
        // On a tie the port that did not win last time takes the slot.
        if (req[GNT_DBG] && (!req[GNT_CPU] || (last_grant == GNT_CPU))) begin
            gnt_id = GNT_DBG;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares one single-port data memory between the cpu MEM stage and
//            a debug/loader port with round-robin arbitration and wait states.
//            Optional macro DMEM_ARB_ALIGN_CHECK_EN adds misalignment errors.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    output logic              cpu_err,
    output logic              dbg_err,
`endif
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [WCNT_W-1:0] c_WAIT_LOAD = WCNT_W'(WAIT_CYCLES - 1);

    state_t              r_state;
    logic [WCNT_W-1:0]   r_wcnt;
    logic                r_last_grant;
    logic                r_gnt_id;
    logic                r_we;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_cpu_rdata;
    logic [DATA_W-1:0]   r_dbg_rdata;
    logic                r_cpu_ack;
    logic                r_dbg_ack;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic                r_cpu_err;
    logic                r_dbg_err;
`endif

    logic                w_gnt_valid;
    logic                w_gnt_id;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_misaligned;

    rr_arb2 u_rr_arb2 (
        .req        ({dbg_req, cpu_req}),
        .last_grant (r_last_grant),
        .gnt_valid  (w_gnt_valid),
        .gnt_id     (w_gnt_id)
    );

    assign w_sel_we    = (w_gnt_id == GNT_DBG) ? dbg_we    : cpu_we;
    assign w_sel_addr  = (w_gnt_id == GNT_DBG) ? dbg_addr  : cpu_addr;
    assign w_sel_wdata = (w_gnt_id == GNT_DBG) ? dbg_wdata : cpu_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign w_misaligned = (w_sel_addr[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_wcnt       <= '0;
            r_last_grant <= GNT_DBG;
            r_gnt_id     <= GNT_CPU;
            r_we         <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_dbg_ack    <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            r_cpu_err    <= 1'b0;
            r_dbg_err    <= 1'b0;
`endif
        end else begin
            r_cpu_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            r_cpu_err <= 1'b0;
            r_dbg_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt_id     <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                        r_we         <= w_sel_we;
                        r_mem_addr   <= w_sel_addr;
                        r_mem_wdata  <= w_sel_wdata;
                        r_wcnt       <= c_WAIT_LOAD;
                        if (w_misaligned) begin
                            // Misaligned access never touches the bank.
                            r_state <= DONE;
                            if (w_gnt_id == GNT_DBG) r_dbg_ack <= 1'b1;
                            else                     r_cpu_ack <= 1'b1;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
                            if (w_gnt_id == GNT_DBG) r_dbg_err <= 1'b1;
                            else                     r_cpu_err <= 1'b1;
`endif
                        end else begin
                            r_state     <= ACCESS;
                            r_mem_read  <= ~w_sel_we;
                            r_mem_write <= w_sel_we;
                        end
                    end
                end
                ACCESS: begin
                    if (r_wcnt == '0) begin
                        if (!r_we) begin
                            if (r_gnt_id == GNT_DBG) r_dbg_rdata <= mem_rdata;
                            else                     r_cpu_rdata <= mem_rdata;
                        end
                        if (r_gnt_id == GNT_DBG) r_dbg_ack <= 1'b1;
                        else                     r_cpu_ack <= 1'b1;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_wcnt <= r_wcnt - WCNT_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = r_cpu_rdata;
    assign dbg_rdata = r_dbg_rdata;
    assign cpu_ack   = r_cpu_ack;
    assign dbg_ack   = r_dbg_ack;
    assign cpu_stall = cpu_req & ~r_cpu_ack;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign cpu_err   = r_cpu_err;
    assign dbg_err   = r_dbg_err;
`endif
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Directed scoreboard bench; three arbiters with WAIT_CYCLES 1/3/4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [N];
    logic        cpu_req   [N];
    logic        cpu_we    [N];
    logic [31:0] cpu_addr  [N];
    logic [31:0] cpu_wdata [N];
    logic [31:0] cpu_rdata [N];
    logic        cpu_ack   [N];
    logic        cpu_stall [N];
    logic        dbg_req   [N];
    logic        dbg_we    [N];
    logic [31:0] dbg_addr  [N];
    logic [31:0] dbg_wdata [N];
    logic [31:0] dbg_rdata [N];
    logic        dbg_ack   [N];
    logic        dbg_stall_unused;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic        cpu_err   [N];
    logic        dbg_err   [N];
`endif
    logic        mem_read  [N];
    logic        mem_write [N];
    logic [31:0] mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];
    logic        busy      [N];

    bit [31:0] mem     [N][16];
    bit        mem_vld [N][16];
    bit [31:0] shadow  [N][16];
    int        rd_cnt  [N];
    int        wr_cnt  [N];
    int        cyc = 0;
    logic [31:0] sb [N*2][$];

    int n_assert = 0;
    int n_fail   = 0;
    int stall_bad = 0;

    function automatic logic [31:0] preset(input int d, input int k);
        return 32'hA500_0000 | (32'(d) << 8) | 32'(k);
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_dut
        dmem_arbiter #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .WAIT_CYCLES ((i == 0) ? 1 : ((i == 1) ? 3 : 4))
        ) u_dut (
            .clk       (clk),
            .reset     (rst[i]),
            .cpu_req   (cpu_req[i]),
            .cpu_we    (cpu_we[i]),
            .cpu_addr  (cpu_addr[i]),
            .cpu_wdata (cpu_wdata[i]),
            .cpu_rdata (cpu_rdata[i]),
            .cpu_ack   (cpu_ack[i]),
            .cpu_stall (cpu_stall[i]),
            .dbg_req   (dbg_req[i]),
            .dbg_we    (dbg_we[i]),
            .dbg_addr  (dbg_addr[i]),
            .dbg_wdata (dbg_wdata[i]),
            .dbg_rdata (dbg_rdata[i]),
            .dbg_ack   (dbg_ack[i]),
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            .cpu_err   (cpu_err[i]),
            .dbg_err   (dbg_err[i]),
`endif
            .mem_read  (mem_read[i]),
            .mem_write (mem_write[i]),
            .mem_addr  (mem_addr[i]),
            .mem_wdata (mem_wdata[i]),
            .mem_rdata (mem_rdata[i]),
            .busy      (busy[i])
        );
        assign mem_rdata[i] = mem_vld[i][mem_addr[i][5:2]] ? mem[i][mem_addr[i][5:2]]
                                                           : preset(i, int'(mem_addr[i][5:2]));
    end

    assign dbg_stall_unused = 1'b0;

    // Memory bank model plus strobe-cycle counters.
    always @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (mem_write[j] === 1'b1) begin
                mem[j][mem_addr[j][5:2]]     <= mem_wdata[j];
                mem_vld[j][mem_addr[j][5:2]] <= 1'b1;
                wr_cnt[j] <= wr_cnt[j] + 1;
            end
            if (mem_read[j] === 1'b1) rd_cnt[j] <= rd_cnt[j] + 1;
        end
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit p, input bit req, input bit we,
                         input logic [31:0] a, input logic [31:0] w);
        if (p) begin
            dbg_req[d] = req; dbg_we[d] = we; dbg_addr[d] = a; dbg_wdata[d] = w;
        end else begin
            cpu_req[d] = req; cpu_we[d] = we; cpu_addr[d] = a; cpu_wdata[d] = w;
        end
    endtask

    function automatic logic get_ack(input int d, input bit p);
        return p ? dbg_ack[d] : cpu_ack[d];
    endfunction

    function automatic logic [31:0] get_rdata(input int d, input bit p);
        return p ? dbg_rdata[d] : cpu_rdata[d];
    endfunction

    // Raises req (kept high on return); lat counts the req cycle as cycle 1.
    task automatic access(input int d, input bit p, input bit we, input logic [31:0] a,
                          input logic [31:0] w, output int lat, output int ack_cyc);
        int slot;
        int seen;
        slot = d * 2 + int'(p);
        seen = 0;
        lat = 0;
        ack_cyc = -1;
        drive(d, p, 1'b1, we, a, w);
        if (we) shadow[d][a[5:2]] = w;
        else    sb[slot].push_back(shadow[d][a[5:2]]);
        for (int n = 2; n <= 60; n++) begin
            tick();
            if (get_ack(d, p) === 1'b1) begin
                seen = 1; lat = n; ack_cyc = cyc;
                break;
            end
            if (!p && cpu_stall[d] !== 1'b1) stall_bad++;
        end
        check($sformatf("ack_seen_d%0d_p%0d", d, p), seen, 1);
        if (seen != 0) begin
            if (!p) check1($sformatf("stall_in_ack_d%0d", d), cpu_stall[d], 1'b0);
            if (!we && sb[slot].size() > 0)
                check($sformatf("rdata_d%0d_p%0d", d, p), get_rdata(d, p), sb[slot].pop_front());
        end
    endtask

    task automatic xfer(input int d, input bit p, input bit we, input logic [31:0] a,
                        input logic [31:0] w, input int exp_lat, input string tag);
        int lat, ac;
        access(d, p, we, a, w, lat, ac);
        check({tag, "_lat"}, lat, exp_lat);
        drive(d, p, 1'b0, 1'b0, a, w);
        tick();
    endtask

    initial begin
        int lat_c, lat_d, ac_c, ac_d, rd0, wr0, seen, acks;
        int cack [4];
        int dack [2];
        logic err_seen;

        for (int j = 0; j < N; j++) begin
            for (int k = 0; k < 16; k++) shadow[j][k] = preset(j, k);
            rst[j] = 1'b1;
            drive(j, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            drive(j, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        repeat (3) tick();
        for (int j = 0; j < N; j++) rst[j] = 1'b0;
        tick();

        for (int j = 0; j < N; j++) begin
            check1("rst_busy", busy[j], 1'b0);
            check1("rst_mem_read", mem_read[j], 1'b0);
            check1("rst_mem_write", mem_write[j], 1'b0);
            check1("rst_cpu_ack", cpu_ack[j], 1'b0);
            check1("rst_dbg_ack", dbg_ack[j], 1'b0);
            check1("rst_cpu_stall", cpu_stall[j], 1'b0);
            check("rst_cpu_rdata", cpu_rdata[j], 32'h0);
            check("rst_dbg_rdata", dbg_rdata[j], 32'h0);
            check("rst_mem_addr", mem_addr[j], 32'h0);
            check("rst_mem_wdata", mem_wdata[j], 32'h0);
        end

        // WAIT_CYCLES=1: store then load through the cpu port.
        wr0 = wr_cnt[0];
        xfer(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, "cpu_wr");
        check("cpu_wr_strobe_cycles", wr_cnt[0] - wr0, 1);
        rd0 = rd_cnt[0];
        xfer(0, 1'b0, 1'b0, 32'h10, 32'h0, 3, "cpu_rd");
        check("cpu_rd_strobe_cycles", rd_cnt[0] - rd0, 1);
        check("cpu_rd_data", cpu_rdata[0], 32'hDEADBEEF);

        // Simultaneous requests straight after reset: cpu wins the tie.
        rst[0] = 1'b1; tick(); rst[0] = 1'b0; tick();
        fork
            begin access(0, 1'b0, 1'b0, 32'h10, 32'h0, lat_c, ac_c); drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); end
            begin access(0, 1'b1, 1'b0, 32'h14, 32'h0, lat_d, ac_d); drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0); end
        join
        tick();
        check("pair1_cpu_lat", lat_c, 3);
        check("pair1_dbg_lat", lat_d, 6);
        check("pair1_gap", ac_d - ac_c, 3);

        // After a cpu win the next tie goes to dbg.
        xfer(0, 1'b0, 1'b0, 32'h18, 32'h0, 3, "cpu_single");
        fork
            begin access(0, 1'b0, 1'b0, 32'h1C, 32'h0, lat_c, ac_c); drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0); end
            begin access(0, 1'b1, 1'b0, 32'h20, 32'h0, lat_d, ac_d); drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0); end
        join
        tick();
        check("pair2_dbg_lat", lat_d, 3);
        check("pair2_cpu_lat", lat_c, 6);

        // Continuous cpu stream with dbg joining mid-stream.
        fork
            begin
                for (int k = 0; k < 4; k++) access(0, 1'b0, 1'b0, 32'h10 + 32'(4 * k), 32'h0, lat_c, cack[k]);
                drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            begin
                repeat (4) tick();
                for (int k = 0; k < 2; k++) access(0, 1'b1, 1'b0, 32'h30 + 32'(4 * k), 32'h0, lat_d, dack[k]);
                drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        join
        tick();
        check("stream_cpu_b2b", cack[1] - cack[0], 3);
        check("stream_dbg_after_cpu", dack[0] - cack[1], 3);
        check("stream_cpu_after_dbg", cack[2] - dack[0], 3);
        check("stream_cpu_period", cack[3] - cack[2], 6);
        check("stream_dbg_period", dack[1] - dack[0], 6);

        // WAIT_CYCLES=3: reset during the second ACCESS cycle.
        xfer(1, 1'b0, 1'b0, 32'h20, 32'h0, 5, "w3_rd");
        drive(1, 1'b0, 1'b1, 1'b0, 32'h24, 32'h0);
        tick();
        check1("w3_strobe_before_rst", mem_read[1], 1'b1);
        tick();
        rst[1] = 1'b1;
        drive(1, 1'b0, 1'b0, 1'b0, 32'h24, 32'h0);
        tick();
        rst[1] = 1'b0;
        check1("midrst_busy", busy[1], 1'b0);
        check1("midrst_mem_read", mem_read[1], 1'b0);
        check1("midrst_mem_write", mem_write[1], 1'b0);
        check1("midrst_cpu_ack", cpu_ack[1], 1'b0);
        check("midrst_cpu_rdata", cpu_rdata[1], 32'h0);
        acks = 0;
        repeat (6) begin
            tick();
            if (cpu_ack[1] === 1'b1 || dbg_ack[1] === 1'b1) acks++;
        end
        check("midrst_no_ack", acks, 0);

        // WAIT_CYCLES=4: dbg read leaves cpu_rdata alone; writes leave rdata alone.
        xfer(2, 1'b0, 1'b0, 32'h24, 32'h0, 6, "w4_cpu_rd");
        rd0 = rd_cnt[2];
        xfer(2, 1'b1, 1'b0, 32'h20, 32'h0, 6, "w4_dbg_rd");
        check("w4_dbg_read_cycles", rd_cnt[2] - rd0, 4);
        check("w4_cpu_rdata_kept", cpu_rdata[2], preset(2, 9));
        wr0 = wr_cnt[2];
        xfer(2, 1'b1, 1'b1, 32'h20, 32'h12345678, 6, "w4_dbg_wr");
        check("w4_dbg_write_cycles", wr_cnt[2] - wr0, 4);
        check("w4_dbg_rdata_after_wr", dbg_rdata[2], preset(2, 8));

        // Request dropped early: the access still completes.
        drive(2, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (cpu_ack[2] === 1'b1) begin seen = 1; break; end
        end
        check("drop_ack_seen", seen, 1);
        check("drop_rdata", cpu_rdata[2], 32'h12345678);
        tick();

        // Misaligned cpu read of 0x13.
        rd0 = rd_cnt[0];
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        drive(0, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0);
        seen = 0; lat_c = 0; err_seen = 1'b0;
        for (int n = 2; n <= 20; n++) begin
            tick();
            if (cpu_ack[0] === 1'b1) begin seen = 1; lat_c = n; err_seen = cpu_err[0]; break; end
        end
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("align_ack_seen", seen, 1);
        check("align_lat", lat_c, 2);
        check1("align_err", err_seen, 1'b1);
        check("align_no_read", rd_cnt[0] - rd0, 0);
        check("align_rdata_kept", cpu_rdata[0], preset(0, 7));
`else
        err_seen = 1'b0;
        xfer(0, 1'b0, 1'b0, 32'h13, 32'h0, 3, "unaligned_rd");
        check("unaligned_read_cycles", rd_cnt[0] - rd0, 1);
        check("unaligned_rdata", cpu_rdata[0], 32'hDEADBEEF);
        check1("unaligned_no_err_flag", err_seen, 1'b0);
`endif

        check("stall_while_waiting", stall_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
